// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types: next-PC select encodings, fetch FSM states, NOP word.
// The op controller imports the same pcsrc encodings.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, decoder output and next-PC controls.
import fetch_unit_pkg::*;

interface fetch_unit_if;
  pcsrc_e          pcsrc;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_result;
  logic            instr_ready;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  // Fetch unit side.
  modport master (
    input  pcsrc, imm_ext, alu_result, instr_ready, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
  );

  // Memory / decoder / op-controller side.
  modport slave (
    output pcsrc, imm_ext, alu_result, instr_ready, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential, branch/jal and jalr targets,
// all modulo 2^32 and word aligned.
import fetch_unit_pkg::*;

module next_pc_sel (
  input  logic [XLEN-1:0] pc_i,
  input  pcsrc_e          pcsrc_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic [XLEN-1:0] target;

  assign pc_plus4_o = pc_i + XLEN'(4);

  always_comb begin
    target = pc_plus4_o;
    unique case (pcsrc_i)
      PC_PLUS4:  target = pc_plus4_o;
      PC_BRANCH: target = pc_i + imm_ext_i;
      PC_JALR:   target = {alu_result_i[XLEN-1:1], 1'b0};
      default:   target = pc_plus4_o;
    endcase
  end

  // Fetch addresses are always word aligned.
  assign next_pc_o = {target[XLEN-1:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests the word at pc, holds it for the decoder
// until retired, then advances pc to the selected target.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            imem_req_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;

  next_pc_sel u_next_pc_sel (
    .pc_i         (pc_q),
    .pcsrc_i      (bus.pcsrc),
    .imm_ext_i    (bus.imm_ext),
    .alu_result_i (bus.alu_result),
    .next_pc_o    (pc_d),
    .pc_plus4_o   (pc_plus4)
  );

  // Acks outside REQ and retires outside HOLD fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= REQ;
          end
        end
        default: begin
          state_q       <= IDLE;
          instr_valid_q <= 1'b0;
          imem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, branch/jalr
// targets, ack wait states, ignored handshakes, wraparound and mid-fetch reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered in REQ; waits wait_n cycles, acks with word, leaves the unit in HOLD.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      chk("wait_req",   32'(bus.imem_req),    32'd1);
      chk("wait_addr",  bus.imem_addr,        exp_addr);
      chk("wait_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    chk("req",  32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr,     exp_addr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    chk("valid",    32'(bus.instr_valid), 32'd1);
    chk("instr",    bus.instr,            word);
    chk("req_low",  32'(bus.imem_req),    32'd0);
    chk("hold_pc",  bus.pc,               exp_addr);
  endtask

  // Entered in HOLD; retires the instruction with the given next-PC controls.
  task automatic retire(input pcsrc_e src, input logic [31:0] imm, input logic [31:0] alu);
    bus.pcsrc       = src;
    bus.imm_ext     = imm;
    bus.alu_result  = alu;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    bus.pcsrc       = PC_PLUS4;
    bus.imm_ext     = 32'h0;
    bus.alu_result  = 32'h0;
    chk("rereq",      32'(bus.imem_req),    32'd1);
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.pcsrc       = PC_PLUS4;
    bus.imm_ext     = 32'h0;
    bus.alu_result  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    tick();
    tick();

    chk("rst_pc",    bus.pc,               32'h0000_0000);
    chk("rst_instr", bus.instr,            32'h0000_0013);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_req",   32'(bus.imem_req),    32'd0);
    chk("rst_p4",    bus.pc_plus4,         32'h0000_0004);

    rst = 1'b0;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    tick();

    // Sequential fetch 0,4,8,C.
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 32'h0010_0093 + 32'(i), 0);
      retire(PC_PLUS4, 32'h0, 32'h0);
    end

    // Branch backwards from 0x10, then forward from 0x10, then unaligned offset.
    fetch(32'h0000_0010, 32'hFE00_0CE3, 0);
    retire(PC_BRANCH, 32'hFFFF_FFF8, 32'h0);
    fetch(32'h0000_0008, 32'h0000_0013, 0);
    retire(PC_JALR, 32'h0, 32'h0000_0010);
    fetch(32'h0000_0010, 32'h0200_006F, 0);
    retire(PC_BRANCH, 32'h0000_0020, 32'h0);
    fetch(32'h0000_0030, 32'h0000_0013, 0);
    retire(PC_BRANCH, 32'h0000_0006, 32'h0);

    // jalr from 0x40 with bits [1:0] set in the target.
    fetch(32'h0000_0034, 32'h0000_0013, 0);
    retire(PC_JALR, 32'h0, 32'h0000_0041);
    fetch(32'h0000_0040, 32'h0000_00E7, 0);
    chk("hold_p4_40", bus.pc_plus4, 32'h0000_0044);
    retire(PC_JALR, 32'h0, 32'h0000_0103);

    // instr_ready while in REQ is ignored.
    bus.instr_ready = 1'b1;
    bus.pcsrc       = PC_JALR;
    bus.alu_result  = 32'h0000_0500;
    tick();
    bus.instr_ready = 1'b0;
    bus.pcsrc       = PC_PLUS4;
    bus.alu_result  = 32'h0;
    chk("rdy_in_req_addr",  bus.imem_addr,        32'h0000_0100);
    chk("rdy_in_req_valid", 32'(bus.instr_valid), 32'd0);

    // Three wait cycles before ack, then a spurious ack during HOLD.
    fetch(32'h0000_0100, 32'h1234_5678, 3);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    chk("spur_instr", bus.instr,            32'h1234_5678);
    chk("spur_valid", 32'(bus.instr_valid), 32'd1);
    chk("spur_pc",    bus.pc,               32'h0000_0100);
    chk("spur_req",   32'(bus.imem_req),    32'd0);
    retire(PC_PLUS4, 32'h0, 32'h0);

    // Wraparound at the top of the address space, via 00 and reserved 11.
    fetch(32'h0000_0104, 32'h0000_0013, 0);
    retire(PC_JALR, 32'h0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    chk("wrap_p4", bus.pc_plus4, 32'h0000_0000);
    retire(PC_PLUS4, 32'h0, 32'h0);
    fetch(32'h0000_0000, 32'h0000_0013, 0);
    retire(PC_JALR, 32'h0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    retire(PC_RSVD, 32'h0, 32'h0);

    // Reset asserted in REQ together with an ack.
    fetch(32'h0000_0000, 32'h0000_0013, 0);
    retire(PC_JALR, 32'h0, 32'h0000_0200);
    chk("pre_rst_addr", bus.imem_addr, 32'h0000_0200);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    rst            = 1'b1;
    #1;
    chk("arst_pc",    bus.pc,               32'h0000_0000);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_req",   32'(bus.imem_req),    32'd0);
    chk("arst_instr", bus.instr,            32'h0000_0013);
    tick();
    rst            = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    chk("post_rst_idle_req", 32'(bus.imem_req),    32'd0);
    chk("post_rst_instr",    bus.instr,            32'h0000_0013);
    chk("post_rst_pc",       bus.pc,               32'h0000_0000);
    tick();
    fetch(32'h0000_0000, 32'h0040_0093, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pcsrc  input  2  next-PC select from the op controller: 00 PC+4, 01 PC+imm, 10 ALU result (jalr), 11 reserved.
REQ-005 imm_ext  input  32  sign-extended immediate for branch/jal target.
REQ-006 alu_result  input  32  jalr target (rs1+imm).
REQ-007 instr_ready  input  1  consumer retires the held instruction this cycle; pcsrc/imm_ext/alu_result are valid when it is high.
REQ-008 imem_ack  input  1  instruction memory returns data this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address; equals pc.
REQ-012 instr  output  32  registered instruction word for the decoder.
REQ-013 instr_valid  output  1  instr holds a fetched, unretired instruction.
REQ-014 pc  output  32  address of the current instruction.
REQ-015 pc_plus4  output  32  pc+4, for jal/jalr link write-back.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ, HOLD.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 In REQ: imem_req=1, imem_addr=pc held stable; on imem_ack, capture imem_rdata into instr and go to HOLD.
REQ-019 In HOLD: instr_valid=1, imem_req=0; on instr_ready, load the next PC and go to REQ.
REQ-020 Next PC: pcsrc 00 -> pc+4; 01 -> pc+imm_ext; 10 -> alu_result with bit 0 cleared; 11 -> pc+4.
REQ-021 All target arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 Targets SHALL have bits [1:0] forced to 00 before loading pc.
REQ-023 imem_ack outside REQ SHALL be ignored (no state, instr or pc change).
REQ-024 instr_ready outside HOLD SHALL be ignored.
REQ-025 Minimum fetch-to-valid latency: 1 cycle (ack in the first REQ cycle -> instr_valid the next cycle); an ack-wait of N cycles adds N cycles.
REQ-026 instr and pc SHALL remain stable throughout HOLD.
REQ-027 pc_plus4 SHALL be combinational from pc.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0.
REQ-029 rst asserted mid-fetch or mid-hold SHALL abort immediately; a pending ack is dropped and no pc update occurs.

Structure
REQ-030 A shared package SHALL hold the pcsrc encodings (PC_PLUS4, PC_BRANCH, PC_JALR), the state enum, and the NOP constant; the op controller uses the same pcsrc constants.
REQ-031 The next-PC mux and adders SHALL be a combinational sub-module, next_pc_sel; the FSM and registers stay in fetch_unit.

Verification
REQ-032 Reset release, ack immediately each REQ, instr_ready=1 with pcsrc=00 -> addresses 0,4,8,C on successive fetches.
REQ-033 pc=0x10, pcsrc=01, imm_ext=0xFFFF_FFF8 -> next imem_addr=0x08; imm_ext=0x20 -> 0x30.
REQ-034 pc=0x40, pcsrc=10, alu_result=0x0000_0103 -> next imem_addr=0x100; pc_plus4=0x44 during HOLD.
REQ-035 Ack delayed 3 cycles -> imem_req high and imem_addr stable for 4 cycles; instr_valid rises the cycle after ack; a spurious ack in HOLD leaves instr unchanged.
REQ-036 rst pulsed during REQ with ack arriving the same cycle -> pc=RESET_PC, instr_valid=0, IDLE for one cycle, then a fetch from RESET_PC.
REQ-037 pc=0xFFFF_FFFC, pcsrc=00 or 11 -> next fetch at 0x0000_0000.
